// File: rtl/seg7_pkg.sv
// seg7_pkg: shared types, the 7-segment pattern table and decode helpers
// for the segment-bus reader (and the matching display encoder).
package seg7_pkg;

  // Step class of an accepted digit relative to the previous one.
  typedef enum logic [1:0] {
    DIR_HOLD = 2'b00,
    DIR_UP   = 2'b01,
    DIR_DOWN = 2'b10,
    DIR_JUMP = 2'b11
  } dir_t;

  // Reader FSM states.
  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    SETTLE = 2'd1,
    LOCKED = 2'd2
  } state_t;

  // Segment patterns for hex digits 0..F; index = nibble, bit0=a .. bit6=g.
  localparam logic [15:0][6:0] SEG7_PATTERNS = {
    7'h71, 7'h79, 7'h5E, 7'h39, 7'h7C, 7'h77, 7'h6F, 7'h7F,
    7'h07, 7'h7D, 7'h6D, 7'h66, 7'h4F, 7'h5B, 7'h06, 7'h3F
  };

  // Returns {is_valid, nibble}; nibble is 0 when the pattern is not a hex digit.
  function automatic logic [4:0] seg7_decode(input logic [6:0] pat);
    logic [4:0] res;
    res = 5'h00;
    for (int i = 0; i < 16; i++) begin
      if (pat == SEG7_PATTERNS[i]) res = {1'b1, 4'(i)};
    end
    return res;
  endfunction

  // Classifies (cur - prev) mod 16: +1 up, -1 down, 0 hold, anything else jump.
  function automatic dir_t seg7_step(input logic [3:0] prev, input logic [3:0] cur);
    logic [3:0] diff;
    dir_t       res;
    diff = cur - prev;
    case (diff)
      4'd0:    res = DIR_HOLD;
      4'd1:    res = DIR_UP;
      4'd15:   res = DIR_DOWN;
      default: res = DIR_JUMP;
    endcase
    return res;
  endfunction

endpackage

// File: rtl/seg7_stabilizer.sv
// seg7_stabilizer: input register, change detect and stability counter.
// 'change' is high on any edge where the bus differs from the last sample
// (that edge captures the new pattern); 'stable' strobes for one cycle on the
// edge where the captured pattern has been seen STABLE_CYCLES more times.
// Build option SEG7_ACTIVE_LOW_EN: store the inverted bus (common-anode display).
module seg7_stabilizer
  import seg7_pkg::*;
#(
  parameter int STABLE_CYCLES = 3
) (
  input  logic       clk_2,
  input  logic       reset_n,
  input  logic [7:0] seg_in,
  output logic       change,
  output logic       stable,
  output logic [6:0] pattern
);

  localparam int CNT_W = (STABLE_CYCLES < 1) ? 1 : $clog2(STABLE_CYCLES + 1);

  logic [6:0]       sample;
  logic [6:0]       seg_q;
  logic [CNT_W-1:0] stab_cnt;
  logic             settling;
  logic             unused_dp;

  // Decimal point never participates in decoding.
  assign unused_dp = seg_in[7];

`ifdef SEG7_ACTIVE_LOW_EN
  assign sample = ~seg_in[6:0];
`else
  assign sample = seg_in[6:0];
`endif

  // Combinational strobes: the consumer registers its outputs on the same
  // edge, so an accepted pattern shows up one cycle after that edge.
  assign change  = (sample != seg_q);
  assign stable  = settling && !change && (stab_cnt == CNT_W'(STABLE_CYCLES - 1));
  assign pattern = seg_q;

  // Sample register, stability counter and settle-in-progress flag.
  always_ff @(posedge clk_2 or negedge reset_n) begin
    if (!reset_n) begin
      seg_q    <= 7'h00;
      stab_cnt <= '0;
      settling <= 1'b0;
    end else begin
      seg_q <= sample;
      if (change) begin
        stab_cnt <= '0;
        settling <= 1'b1;
      end else if (settling) begin
        stab_cnt <= stab_cnt + CNT_W'(1);
        if (stable) settling <= 1'b0;
      end
    end
  end

endmodule

// File: rtl/seg7_reader.sv
// seg7_reader: receiving end of the 7-segment display bus. Waits for each
// pattern to settle, decodes it to a hex nibble, keeps a digit history,
// classifies each step and counts invalid patterns (saturating).
// Build option SEG7_ACTIVE_LOW_EN (handled in seg7_stabilizer).
//
// Handshake: valid and invalid_pattern are single-cycle strobes with no
// backpressure; digit/dir/history are stable from the cycle valid is high
// until the next valid.
module seg7_reader
  import seg7_pkg::*;
#(
  parameter int STABLE_CYCLES = 3,
  parameter int HIST_DEPTH    = 4,
  parameter int NBITS_ERR     = 8
) (
  input  logic                    clk_2,
  input  logic                    reset_n,
  input  logic [7:0]              seg_in,
  output logic                    valid,
  output logic [3:0]              digit,
  output logic [1:0]              dir,
  output logic [4*HIST_DEPTH-1:0] history,
  output logic                    invalid_pattern,
  output logic [NBITS_ERR-1:0]    err_count,
  output logic [1:0]              state_dbg
);

  localparam logic [1:0] S_IDLE   = IDLE;
  localparam logic [1:0] S_SETTLE = SETTLE;
  localparam logic [1:0] S_LOCKED = LOCKED;

  logic                    stab_change;
  logic                    stab_strobe;
  logic [6:0]              stab_pattern;
  logic [1:0]              state;
  logic [6:0]              locked_pat;
  logic                    have_locked;
  logic                    have_prev;
  logic [4:0]              dec;
  logic                    accept;
  logic [4*HIST_DEPTH-1:0] hist_next;

  seg7_stabilizer #(
    .STABLE_CYCLES(STABLE_CYCLES)
  ) u_stab (
    .clk_2  (clk_2),
    .reset_n(reset_n),
    .seg_in (seg_in),
    .change (stab_change),
    .stable (stab_strobe),
    .pattern(stab_pattern)
  );

  assign dec       = seg7_decode(stab_pattern);
  // A settled pattern equal to the one already locked is a return, not news.
  assign accept    = (state == S_SETTLE) && stab_strobe &&
                     (!have_locked || (stab_pattern != locked_pat));
  assign state_dbg = state;

  if (HIST_DEPTH > 1) begin : g_hist_shift
    assign hist_next = {history[4*HIST_DEPTH-5:0], dec[3:0]};
  end else begin : g_hist_single
    assign hist_next = dec[3:0];
  end

  // FSM: any change restarts settling; a completed settle returns to LOCKED.
  always_ff @(posedge clk_2 or negedge reset_n) begin
    if (!reset_n) begin
      state <= S_IDLE;
    end else if (stab_change) begin
      state <= S_SETTLE;
    end else if ((state == S_SETTLE) && stab_strobe) begin
      state <= S_LOCKED;
    end
  end

  // Accept path: locked pattern, decoded outputs, history and error counter.
  always_ff @(posedge clk_2 or negedge reset_n) begin
    if (!reset_n) begin
      valid           <= 1'b0;
      invalid_pattern <= 1'b0;
      digit           <= 4'h0;
      dir             <= DIR_HOLD;
      history         <= '0;
      err_count       <= '0;
      locked_pat      <= 7'h00;
      have_locked     <= 1'b0;
      have_prev       <= 1'b0;
    end else begin
      valid           <= 1'b0;
      invalid_pattern <= 1'b0;
      if (accept) begin
        locked_pat  <= stab_pattern;
        have_locked <= 1'b1;
        if (dec[4]) begin
          valid     <= 1'b1;
          digit     <= dec[3:0];
          dir       <= have_prev ? seg7_step(digit, dec[3:0]) : DIR_HOLD;
          history   <= hist_next;
          have_prev <= 1'b1;
        end else begin
          invalid_pattern <= 1'b1;
          if (err_count != '1) err_count <= err_count + NBITS_ERR'(1);
        end
      end
    end
  end

endmodule

// File: tb/tb_seg7_reader.sv
// tb_seg7_reader: directed bench for seg7_reader (default parameters).
module tb_seg7_reader;

  logic        clk_2;
  logic        reset_n;
  logic [7:0]  seg_in;
  logic        valid;
  logic [3:0]  digit;
  logic [1:0]  dir;
  logic [15:0] history;
  logic        invalid_pattern;
  logic [7:0]  err_count;
  logic [1:0]  state_dbg;

  int passed = 0;
  int total  = 0;
  int vcnt, icnt, first_v, both_cnt, vsum, isum;

  seg7_reader #(
    .STABLE_CYCLES(3),
    .HIST_DEPTH   (4),
    .NBITS_ERR    (8)
  ) dut (
    .clk_2          (clk_2),
    .reset_n        (reset_n),
    .seg_in         (seg_in),
    .valid          (valid),
    .digit          (digit),
    .dir            (dir),
    .history        (history),
    .invalid_pattern(invalid_pattern),
    .err_count      (err_count),
    .state_dbg      (state_dbg)
  );

  // Clock / reset block
  initial clk_2 = 1'b0;
  always #5 clk_2 = ~clk_2;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) passed++;
    else $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
  endtask

  // Drive a pattern at a negedge and hold it n cycles, counting pulses seen
  // at each following negedge. first_v = cycle index of the first valid.
  task automatic hold(input logic [7:0] pat, input int n);
    seg_in  = pat;
    vcnt    = 0;
    icnt    = 0;
    first_v = -1;
    for (int i = 1; i <= n; i++) begin
      @(negedge clk_2);
      if (valid) begin
        vcnt++;
        if (first_v < 0) first_v = i;
      end
      if (invalid_pattern) icnt++;
      if (valid && invalid_pattern) both_cnt++;
    end
  endtask

  task automatic do_reset();
    seg_in  = 8'h00;
    reset_n = 1'b0;
    repeat (3) @(negedge clk_2);
    reset_n = 1'b1;
  endtask

  initial begin
    both_cnt = 0;
    reset_n  = 1'b0;
    seg_in   = 8'h00;
    repeat (2) @(negedge clk_2);
    check("rst_valid", valid, 0);
    check("rst_digit", digit, 0);
    check("rst_dir", dir, 0);
    check("rst_history", history, 0);
    check("rst_invalid", invalid_pattern, 0);
    check("rst_err", err_count, 0);
    check("rst_state", state_dbg, 0);
    reset_n = 1'b1;

    // Bus idle at 00 after reset: nothing to report.
    hold(8'h00, 8);
    check("idle_valid", vcnt, 0);
    check("idle_invalid", icnt, 0);
    check("idle_err", err_count, 0);

    // First digit: one pulse, in the cycle after edge 3.
    hold(8'h3F, 10);
    check("d0_vcnt", vcnt, 1);
    check("d0_timing", first_v, 4);
    check("d0_digit", digit, 4'h0);
    check("d0_dir", dir, 2'b00);
    check("d0_history", history, 16'h0000);
    check("d0_state", state_dbg, 2'd2);

    // Fresh reset, then 1,2,3,1.
    do_reset();
    hold(8'h06, 6);
    check("s1_vcnt", vcnt, 1);
    check("s1_digit", digit, 4'h1);
    check("s1_dir", dir, 2'b00);
    hold(8'h5B, 6);
    check("s2_digit", digit, 4'h2);
    check("s2_dir", dir, 2'b01);
    hold(8'h4F, 6);
    check("s3_digit", digit, 4'h3);
    check("s3_dir", dir, 2'b01);
    hold(8'h06, 6);
    check("s4_digit", digit, 4'h1);
    check("s4_dir", dir, 2'b11);
    check("s4_history", history, 16'h1231);

    // Wrap-around.
    hold(8'h71, 6);
    check("wF_digit", digit, 4'hF);
    check("wF_dir", dir, 2'b11);
    hold(8'h3F, 6);
    check("w0_digit", digit, 4'h0);
    check("w0_dir_up", dir, 2'b01);
    hold(8'h71, 6);
    check("wF2_dir_down", dir, 2'b10);

    // Invalid pattern between two identical digits.
    hold(8'h4F, 6);
    check("i3_digit", digit, 4'h3);
    check("i3_dir", dir, 2'b11);
    hold(8'h00, 6);
    check("inv_pulses", icnt, 1);
    check("inv_valid", vcnt, 0);
    check("inv_err", err_count, 1);
    check("inv_digit_kept", digit, 4'h3);
    hold(8'h4F, 6);
    check("hold_vcnt", vcnt, 1);
    check("hold_dir", dir, 2'b00);
    check("hold_history", history, 16'h0F33);

    // Short glitch inside a steady pattern.
    hold(8'h06, 2);
    vsum = vcnt; isum = icnt;
    hold(8'h4F, 8);
    check("glitch_pulses", vsum + isum + vcnt + icnt, 0);
    check("glitch_digit", digit, 4'h3);
    check("glitch_err", err_count, 1);

    // Asynchronous reset in the middle of a settle.
    hold(8'h5B, 2);
    #2 reset_n = 1'b0;
    #1;
    check("mid_valid", valid, 0);
    check("mid_digit", digit, 0);
    check("mid_history", history, 0);
    check("mid_err", err_count, 0);
    check("mid_state", state_dbg, 0);
    seg_in = 8'h00;
    @(negedge clk_2);
    reset_n = 1'b1;
    hold(8'h00, 8);
    check("post_rst_valid", vcnt, 0);
    check("post_rst_digit", digit, 0);

    // Error counter saturation with alternating invalid patterns.
    vsum = 0; isum = 0;
    for (int k = 0; k < 100; k++) begin
      hold((k % 2 == 0) ? 8'h01 : 8'h00, 5);
      vsum += vcnt; isum += icnt;
    end
    check("sat_err_100", err_count, 100);
    for (int k = 100; k < 300; k++) begin
      hold((k % 2 == 0) ? 8'h01 : 8'h00, 5);
      vsum += vcnt; isum += icnt;
    end
    check("sat_err_300", err_count, 255);
    check("sat_inv_pulses", isum, 300);
    check("sat_valid", vsum, 0);
    hold(8'h01, 5);
    check("sat_hold", err_count, 255);
    check("sat_last_pulse", icnt, 1);

    check("never_both", both_cnt, 0);

    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule
